fetch_pc_ctrl: RTL

- Owns the F-stage program counter register for the 5-stage MIPS pipeline, and sequences every PC update.
- Arbitrates between these redirect sources: exception/interrupt entry, eret return, D-stage branch/jump redirect, stall hold and sequential +4.
- Buffers a branch redirect that resolves while F is stalled, so the delay slot is fetched exactly once.
- Produces the delay-slot flag (BD) and the fetch exception code that travel down the pipe with each fetched instruction.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/fetch_adel_check.sv | 18 +
 rtl/fetch_pc_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: address map defaults, exception codes
// and the fetch-PC controller state encoding.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;
    localparam logic [31:0] IM_LO_DEF    = 32'h0000_3000;
    localparam logic [31:0] IM_HI_DEF    = 32'h0000_6FFC;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } pc_state_e;

    // Word-aligned and inside [lo, hi].
    function automatic logic addr_legal(input logic [31:0] addr,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
        return (addr[1:0] == 2'b00) && (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/fetch_adel_check.sv
// Combinational address-error check: flags misaligned or out-of-range
// addresses and reports CODE. Shared by the fetch and load/store stages.
module fetch_adel_check
    import mips_pkg::*;
#(
    parameter logic [31:0] LO   = IM_LO_DEF,
    parameter logic [31:0] HI   = IM_HI_DEF,
    parameter logic [4:0]  CODE = EXC_ADEL
) (
    input  logic [31:0] addr,
    output logic        exc,
    output logic [4:0]  code
);

    assign exc  = !addr_legal(addr, LO, HI);
    assign code = exc ? CODE : EXC_INT;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// F-stage PC owner and redirect sequencer with one-entry branch buffer.
// Define FETCH_ADEL_EN to enable the fetch address-error (AdEL) check.
module fetch_pc_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_PC   = EXC_PC_DEF
`ifdef FETCH_ADEL_EN
    ,
    parameter logic [31:0] IM_LO    = IM_LO_DEF,
    parameter logic [31:0] IM_HI    = IM_HI_DEF
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        f_is_branch,
    output logic [31:0] F_PC,
    output logic        F_BD,
    output logic        F_exc,
    output logic [4:0]  F_ExcCode,
    output logic        flush_fd,
    output logic        pending
);

    pc_state_e   state, next_state;
    logic [31:0] pend_target, next_target;
    logic [31:0] next_pc;
    logic        next_bd;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed by the comb block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            F_PC        <= RESET_PC;
            F_BD        <= 1'b0;
            pend_target <= '0;
        end else begin
            state       <= next_state;
            F_PC        <= next_pc;
            F_BD        <= next_bd;
            pend_target <= next_target;
        end
    end

    // NOTE: every output is defaulted to its held value first, so no path
    // through the priority chain can infer a latch.
    always_comb begin
        next_state  = state;
        next_pc     = F_PC;
        next_bd     = F_BD;
        next_target = pend_target;
        if (req) begin
            next_pc    = EXC_PC;
            next_bd    = 1'b0;
            next_state = RUN;
        end else if (eret) begin
            next_pc    = epc;
            next_bd    = 1'b0;
            next_state = RUN;
        end else if (state == PEND) begin
            // A br_taken seen here is the buffered branch still presenting.
            if (!stall) begin
                next_pc    = pend_target;
                next_bd    = f_is_branch;
                next_state = RUN;
            end
        end else if (stall) begin
            if (br_taken) begin
                next_target = br_target;
                next_state  = PEND;
            end
        end else if (br_taken) begin
            next_pc = br_target;
            next_bd = f_is_branch;
        end else begin
            next_pc = F_PC + 32'd4;
            next_bd = f_is_branch;
        end
    end

    // eret has no delay slot, so the instruction behind it is squashed.
    always_comb begin
        pending  = (state == PEND);
        flush_fd = eret && !req && !reset;
    end

`ifdef FETCH_ADEL_EN
    fetch_adel_check #(
        .LO   (IM_LO),
        .HI   (IM_HI),
        .CODE (EXC_ADEL)
    ) u_adel (
        .addr (F_PC),
        .exc  (F_exc),
        .code (F_ExcCode)
    );
`else
    assign F_exc     = 1'b0;
    assign F_ExcCode = EXC_INT;
`endif

endmodule
